// File: rtl/servo_pkg.sv
// Shared definitions for the servo angle datapath.
// Holds the FSM state encoding, the angle width and the mechanical angle
// limit. The servo PWM driver imports the same package, so both agree on
// what an angle is.
package servo_pkg;

    localparam int ANGLE_W = 8;
    localparam logic [ANGLE_W-1:0] MAX_ANGLE = 8'd180;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RAMP   = 2'd1,
        ST_SETTLE = 2'd2
    } servo_state_e;

    // Limit a requested angle to the mechanical range 0..MAX_ANGLE.
    function automatic logic [ANGLE_W-1:0] clamp_angle(input logic [ANGLE_W-1:0] a);
        return (a > MAX_ANGLE) ? MAX_ANGLE : a;
    endfunction

endpackage

// File: rtl/servo_step_tick.sv
// Step-period timer for the servo ramp.
// Counts 0..STEP_PERIOD-1 while enabled and wraps to 0. The tick output is a
// registered one-cycle pulse raised on the edge where the count wraps, so the
// consumer sees it in the cycle after the wrap.
//
// Ports:
//   clk    - system clock
//   rst    - asynchronous active-high reset
//   clear  - synchronous clear of the count and tick (priority over enable)
//   enable - count advances while high
//   tick   - one-cycle step pulse
module servo_step_tick #(
    parameter int STEP_PERIOD = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam logic [19:0] LAST = 20'(STEP_PERIOD - 1);

    logic [19:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= 20'd0;
            tick <= 1'b0;
        end else if (clear) begin
            cnt  <= 20'd0;
            tick <= 1'b0;
        end else if (enable) begin
            tick <= (cnt == LAST);
            cnt  <= (cnt == LAST) ? 20'd0 : cnt + 20'd1;
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/servo_angle_ramp.sv
// Rate-limited servo angle ramp.
// Accepts target-angle commands and walks angle_val toward the target by at
// most STEP_DEG degrees every STEP_PERIOD cycles, then holds at the target
// for SETTLE_STEPS step periods before reporting completion.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_valid may be held without waiting for
// cmd_ready, and cmd_ready never depends on cmd_valid.
//
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   cmd_valid    - target command present
//   cmd_angle    - requested target angle (degrees, values >180 are clamped)
//   cmd_ready    - command can be accepted this cycle
//   abort        - stop immediately, hold the current angle
//   angle_val    - registered output angle, 0..180
//   busy         - high while ramping or settling
//   done         - one-cycle pulse on motion completion
//   cmd_clamped  - one-cycle pulse after accepting an out-of-range command
//   state        - current FSM state (debug)
module servo_angle_ramp
    import servo_pkg::*;
#(
    parameter int STEP_PERIOD  = 500000,
    parameter int STEP_DEG     = 1,
    parameter int SETTLE_STEPS = 25,
    parameter int INIT_ANGLE   = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    input  logic [ANGLE_W-1:0] cmd_angle,
    output logic               cmd_ready,
    input  logic               abort,
    output logic [ANGLE_W-1:0] angle_val,
    output logic               busy,
    output logic               done,
    output logic               cmd_clamped,
    output servo_state_e       state
);

    localparam logic [ANGLE_W-1:0] INIT_A     = ANGLE_W'(INIT_ANGLE);
    localparam logic [8:0]         STEP9      = 9'(STEP_DEG);
    localparam logic [15:0]        SETTLE_END = 16'(SETTLE_STEPS - 1);

    servo_state_e       state_q, state_d;
    logic [ANGLE_W-1:0] angle_q, angle_d;
    logic [ANGLE_W-1:0] target_q, target_d;
    logic [15:0]        settle_q, settle_d;
    logic               done_q, done_d;
    logic               clamped_q, clamped_d;
    logic               busy_q;

    logic               tick;
    logic               accept;
    logic [ANGLE_W-1:0] cmd_clamp;
    logic [ANGLE_W-1:0] tgt_eff;
    logic [8:0]         diff;
    logic [8:0]         mag;
    logic [ANGLE_W-1:0] step_amt;
    logic [ANGLE_W-1:0] angle_stepped;

    // Timer runs only while moving or settling; held at zero in IDLE so an
    // accept from IDLE always starts a fresh step period.
    servo_step_tick #(
        .STEP_PERIOD(STEP_PERIOD)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clear  (abort || (state_q == ST_IDLE)),
        .enable (state_q != ST_IDLE),
        .tick   (tick)
    );

    assign cmd_ready = (state_q != ST_SETTLE) && !abort;
    assign accept    = cmd_valid && cmd_ready;
    assign cmd_clamp = clamp_angle(cmd_angle);

    // A command accepted on a step edge steers that step already.
    assign tgt_eff = accept ? cmd_clamp : target_q;

    // 9-bit two's-complement difference; bit 8 is the direction.
    assign diff          = {1'b0, tgt_eff} - {1'b0, angle_q};
    assign mag           = diff[8] ? (~diff + 9'd1) : diff;
    assign step_amt      = (mag > STEP9) ? STEP9[ANGLE_W-1:0] : mag[ANGLE_W-1:0];
    assign angle_stepped = diff[8] ? (angle_q - step_amt) : (angle_q + step_amt);

    always_comb begin
        state_d   = state_q;
        angle_d   = angle_q;
        target_d  = target_q;
        settle_d  = settle_q;
        done_d    = 1'b0;
        clamped_d = 1'b0;

        if (abort) begin
            state_d  = ST_IDLE;
            target_d = angle_q;
            settle_d = 16'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        target_d  = cmd_clamp;
                        clamped_d = (cmd_angle > MAX_ANGLE);
                        if (cmd_clamp == angle_q) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = ST_RAMP;
                        end
                    end
                end
                ST_RAMP: begin
                    if (accept) begin
                        target_d  = cmd_clamp;
                        clamped_d = (cmd_angle > MAX_ANGLE);
                    end
                    if (tick) begin
                        if (tgt_eff == angle_q) begin
                            state_d  = ST_SETTLE;
                            settle_d = 16'd0;
                        end else begin
                            angle_d = angle_stepped;
                            if (angle_stepped == tgt_eff) begin
                                state_d  = ST_SETTLE;
                                settle_d = 16'd0;
                            end
                        end
                    end
                end
                ST_SETTLE: begin
                    if (tick) begin
                        if (settle_q == SETTLE_END) begin
                            state_d  = ST_IDLE;
                            settle_d = 16'd0;
                            done_d   = 1'b1;
                        end else begin
                            settle_d = settle_q + 16'd1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            angle_q   <= INIT_A;
            target_q  <= INIT_A;
            settle_q  <= 16'd0;
            done_q    <= 1'b0;
            clamped_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            angle_q   <= angle_d;
            target_q  <= target_d;
            settle_q  <= settle_d;
            done_q    <= done_d;
            clamped_q <= clamped_d;
            busy_q    <= (state_d != ST_IDLE);
        end
    end

    assign angle_val   = angle_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cmd_clamped = clamped_q;
    assign state       = state_q;

endmodule

// File: tb/tb_servo_angle_ramp.sv
// Bench for servo_angle_ramp with STEP_PERIOD=4, STEP_DEG=3, SETTLE_STEPS=2.
// Directed sequences plus a table of moves with hand-computed completion
// times: for a move of k steps accepted at edge N, done is seen after edge
// N + 1 + 4*(k+2).
module tb_servo_angle_ramp;
    import servo_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic [7:0]   cmd_angle = 8'd0;
    logic         cmd_ready;
    logic         abort = 1'b0;
    logic [7:0]   angle_val;
    logic         busy;
    logic         done;
    logic         cmd_clamped;
    servo_state_e state;

    int checks = 0;
    int errors = 0;

    servo_angle_ramp #(
        .STEP_PERIOD (4),
        .STEP_DEG    (3),
        .SETTLE_STEPS(2),
        .INIT_ANGLE  (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_angle  (cmd_angle),
        .cmd_ready  (cmd_ready),
        .abort      (abort),
        .angle_val  (angle_val),
        .busy       (busy),
        .done       (done),
        .cmd_clamped(cmd_clamped),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] final_ang;
        int         clamped;
        int         done_t;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    int         done_cnt, done_at, clamp_cnt, clamp_at, over, jump, delta;
    logic [7:0] prev;
    logic [7:0] ang_hist[40];
    logic [7:0] exp_ramp[4];

    initial begin
        // move table, run back to back starting from angle 10
        vecs[0] = '{cmd: 8'd200, final_ang: 8'd180, clamped: 1, done_t: 237};
        vecs[1] = '{cmd: 8'd175, final_ang: 8'd175, clamped: 0, done_t: 17};
        vecs[2] = '{cmd: 8'd181, final_ang: 8'd180, clamped: 1, done_t: 17};
        vecs[3] = '{cmd: 8'd0,   final_ang: 8'd0,   clamped: 0, done_t: 249};
        vecs[4] = '{cmd: 8'd0,   final_ang: 8'd0,   clamped: 0, done_t: 0};
        vecs[5] = '{cmd: 8'd2,   final_ang: 8'd2,   clamped: 0, done_t: 13};
        exp_ramp[0] = 8'd3;
        exp_ramp[1] = 8'd6;
        exp_ramp[2] = 8'd9;
        exp_ramp[3] = 8'd10;

        // ---- reset state ----
        step();
        step();
        check("rst_angle", angle_val, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_clamped", cmd_clamped, 0);
        rst = 1'b0;
        step();
        check("post_rst_ready", cmd_ready, 1);
        check("post_rst_state", state, ST_IDLE);

        // ---- basic ramp 0 -> 10 ----
        cmd_angle = 8'd10;
        cmd_valid = 1'b1;
        done_cnt = 0;
        done_at = -1;
        for (int t = 0; t < 40; t++) begin
            step();
            if (t == 0) cmd_valid = 1'b0;
            ang_hist[t] = angle_val;
            if (done) begin done_cnt++; done_at = t; end
            if (t == 1) check("ramp_busy_t1", busy, 1);
            if (t == 18) check("settle_ready_low", cmd_ready, 0);
        end
        check("ramp_hold_t4", ang_hist[4], 0);
        for (int s = 0; s < 4; s++) begin
            check("ramp_step_angle", ang_hist[5 + 4*s], exp_ramp[s]);
            check("ramp_step_hold", ang_hist[8 + 4*s], exp_ramp[s]);
        end
        check("ramp_done_count", done_cnt, 1);
        check("ramp_done_time", done_at, 25);
        check("ramp_busy_end", busy, 0);

        // ---- table of moves ----
        for (int i = 0; i < 6; i++) begin
            done_cnt = 0; done_at = -1; clamp_cnt = 0; clamp_at = -1;
            over = 0; jump = 0;
            prev = angle_val;
            cmd_angle = vecs[i].cmd;
            cmd_valid = 1'b1;
            for (int t = 0; t <= vecs[i].done_t + 4; t++) begin
                step();
                if (t == 0) cmd_valid = 1'b0;
                if (done) begin done_cnt++; done_at = t; end
                if (cmd_clamped) begin clamp_cnt++; clamp_at = t; end
                if (angle_val > 8'd180) over = 1;
                delta = (angle_val > prev) ? int'(angle_val - prev) : int'(prev - angle_val);
                if (delta > 3) jump = 1;
                prev = angle_val;
            end
            check("vec_done_count", done_cnt, 1);
            check("vec_done_time", done_at, vecs[i].done_t);
            check("vec_clamp_count", clamp_cnt, vecs[i].clamped);
            check("vec_clamp_time", clamp_at, (vecs[i].clamped != 0) ? 0 : -1);
            check("vec_final_angle", angle_val, vecs[i].final_ang);
            check("vec_busy_end", busy, 0);
            check("vec_over_180", over, 0);
            check("vec_step_size", jump, 0);
        end

        // ---- null move at 0 via cmd 2 -> return to 0 ----
        cmd_angle = 8'd0;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        done_cnt = 0;
        for (int t = 0; t < 30; t++) begin
            step();
            if (done) done_cnt++;
        end
        check("return_zero", angle_val, 0);

        // ---- retarget 0 -> 30, at 9 retarget to 3 ----
        cmd_angle = 8'd30;
        cmd_valid = 1'b1;
        done_cnt = 0;
        done_at = -1;
        for (int t = 0; t < 36; t++) begin
            step();
            if (t == 0) cmd_valid = 1'b0;
            if (t == 13) begin
                check("retgt_at9", angle_val, 9);
                cmd_angle = 8'd3;
                cmd_valid = 1'b1;
            end
            if (t == 14) cmd_valid = 1'b0;
            ang_hist[t] = angle_val;
            if (done) begin done_cnt++; done_at = t; end
        end
        check("retgt_hold16", ang_hist[16], 9);
        check("retgt_step17", ang_hist[17], 6);
        check("retgt_hold20", ang_hist[20], 6);
        check("retgt_step21", ang_hist[21], 3);
        check("retgt_done_time", done_at, 29);
        check("retgt_done_count", done_cnt, 1);
        check("retgt_final", angle_val, 3);

        // ---- abort at angle 6 together with a command ----
        cmd_angle = 8'd20;
        cmd_valid = 1'b1;
        for (int t = 0; t < 6; t++) begin
            step();
            if (t == 0) cmd_valid = 1'b0;
        end
        check("abort_pre_angle", angle_val, 6);
        abort = 1'b1;
        cmd_valid = 1'b1;
        cmd_angle = 8'd100;
        #1;
        check("abort_ready_low", cmd_ready, 0);
        step();
        abort = 1'b0;
        cmd_valid = 1'b0;
        check("abort_state", state, ST_IDLE);
        check("abort_busy", busy, 0);
        check("abort_angle", angle_val, 6);
        done_cnt = (done === 1'b1) ? 1 : 0;
        over = 0;
        for (int t = 0; t < 16; t++) begin
            step();
            if (done) done_cnt++;
            if (angle_val != 8'd6 || busy) over = 1;
        end
        check("abort_no_done", done_cnt, 0);
        check("abort_cmd_dropped", over, 0);

        // ---- reset mid-ramp ----
        cmd_angle = 8'd50;
        cmd_valid = 1'b1;
        for (int t = 0; t < 10; t++) begin
            step();
            if (t == 0) cmd_valid = 1'b0;
        end
        check("mid_ramp_angle", angle_val, 12);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_angle", angle_val, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_state", state, ST_IDLE);
        step();
        rst = 1'b0;
        step();
        check("rst_release_ready", cmd_ready, 1);
        over = 0;
        for (int t = 0; t < 12; t++) begin
            step();
            if (angle_val != 8'd0 || busy) over = 1;
        end
        check("rst_motion_discarded", over, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
